// File: rtl/gpio_pkg.sv
// gpio_pkg: register word indices and debounce counter sizing shared by the GPIO port
package gpio_pkg;
  localparam logic [2:0] REG_DATA_IN    = 3'd0;
  localparam logic [2:0] REG_DATA_OUT   = 3'd1;
  localparam logic [2:0] REG_IRQ_EN     = 3'd2;
  localparam logic [2:0] REG_EDGE_SEL   = 3'd3;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd4;
  function automatic int cnt_width(input int deb);
    return deb > 1 ? $clog2(deb) : 1;
  endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin -> 2-flop sync, stability counter, stable level plus rise/fall pulses
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEB_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic stable_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      stable_d <= stable;
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  // pulses last the one cycle after the stable level has moved
  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;
endmodule

// File: rtl/gpio_port.sv
// gpio_port: debounced GPIO inputs, output register and edge interrupts on a 5-bit word bus
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] GPIO_i,
  output logic [WIDTH-1:0] GPIO_o,
  input  logic [4:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic             irq
);
  logic [WIDTH-1:0] data_in, rise, fall, data_out, irq_en, edge_sel, irq_status, evt, clr;
  logic [31:0] rd_mux;
  logic [2:0] idx;
  logic unused;
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .pin(GPIO_i[i]),
      .stable(data_in[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  assign idx = addr[4:2];
  assign unused = ^{addr[1:0], wdata};
  assign evt = (rise & edge_sel) | (fall & ~edge_sel);
  assign clr = (we && idx == REG_IRQ_STATUS) ? wdata[WIDTH-1:0] : '0;
  always_comb
    rd_mux = idx == REG_DATA_IN    ? 32'(data_in) :
             idx == REG_DATA_OUT   ? 32'(data_out) :
             idx == REG_IRQ_EN     ? 32'(irq_en) :
             idx == REG_EDGE_SEL   ? 32'(edge_sel) :
             idx == REG_IRQ_STATUS ? 32'(irq_status) : 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      irq_en <= '0;
      edge_sel <= '0;
      irq_status <= '0;
      rdata <= '0;
      ack <= 1'b0;
    end else begin
      if (we && idx == REG_DATA_OUT) data_out <= wdata[WIDTH-1:0];
      if (we && idx == REG_IRQ_EN) irq_en <= wdata[WIDTH-1:0];
      if (we && idx == REG_EDGE_SEL) edge_sel <= wdata[WIDTH-1:0];
      // a new event on the same bit overrides the W1C clear
      irq_status <= (irq_status & ~clr) | evt;
      if (re) rdata <= rd_mux;
      ack <= we | re;
    end
  end
  assign GPIO_o = data_out;
  assign irq = |(irq_status & irq_en);
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed self-checking bench for gpio_port
module tb_gpio_port;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] gpio_i, gpio_o;
  logic [4:0] addr;
  logic we, re, ack, irq;
  logic [31:0] wdata, rdata;
  logic [0:0] p1, o1;
  logic [31:0] p32, o32;
  logic [4:0] s_addr;
  logic s_we, s_re;
  logic [31:0] s_wdata, rd1, rd32;
  logic ack1, ack32, irq1, irq32;
  int checks = 0;
  int failures = 0;
  logic [31:0] v;
  int lat1, lat32;

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .GPIO_i(gpio_i), .GPIO_o(gpio_o), .addr(addr),
    .we(we), .re(re), .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq)
  );
  gpio_port #(.WIDTH(1), .DEB_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .GPIO_i(p1), .GPIO_o(o1), .addr(s_addr),
    .we(s_we), .re(s_re), .wdata(s_wdata), .rdata(rd1), .ack(ack1), .irq(irq1)
  );
  gpio_port #(.WIDTH(32), .DEB_CYCLES(255)) dut32 (
    .clk(clk), .rst(rst), .GPIO_i(p32), .GPIO_o(o32), .addr(s_addr),
    .we(s_we), .re(s_re), .wdata(s_wdata), .rdata(rd32), .ack(ack32), .irq(irq32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("write_ack", 32'(ack), 32'd1);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
    chk("read_ack", 32'(ack), 32'd1);
  endtask

  initial begin
    rst = 1'b1; gpio_i = 8'h0F; addr = 5'h04; wdata = 32'hFF; we = 1'b1; re = 1'b1;
    p1 = 1'b0; p32 = '0; s_addr = 5'h00; s_we = 1'b0; s_re = 1'b0; s_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gpio_o", 32'(gpio_o), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0; we = 1'b0; re = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      rd(5'h00, v);
      chk($sformatf("rst_data_in_%0d", i), v, i == 7 ? 32'h0F : 32'h00);
    end
    rst = 1'b1; gpio_i = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr(5'h0C, 32'h01);
    wr(5'h08, 32'h01);
    gpio_i = 8'h01;
    repeat (3) @(negedge clk);
    gpio_i = 8'h00;
    repeat (10) @(negedge clk);
    rd(5'h00, v); chk("glitch_data_in", v, 32'h00);
    rd(5'h10, v); chk("glitch_status", v, 32'h00);
    chk("glitch_irq", 32'(irq), 32'd0);
    gpio_i = 8'h01;
    repeat (6) @(negedge clk);
    chk("rise_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    chk("rise_irq", 32'(irq), 32'd1);
    rd(5'h10, v); chk("rise_status", v, 32'h01);
    wr(5'h10, 32'h01);
    chk("w1c_irq", 32'(irq), 32'd0);
    rd(5'h10, v); chk("w1c_status", v, 32'h00);
    gpio_i = 8'h05;
    repeat (10) @(negedge clk);
    rd(5'h10, v); chk("rise_not_selected", v, 32'h00);
    gpio_i = 8'h01;
    repeat (6) @(negedge clk);
    wr(5'h10, 32'h04);
    rd(5'h10, v); chk("set_wins_status", v, 32'h04);
    chk("set_wins_irq", 32'(irq), 32'd0);
    wr(5'h10, 32'h04);
    rd(5'h10, v); chk("bit2_cleared", v, 32'h00);
    wr(5'h04, 32'hFFFFFFA5);
    chk("gpio_o_a5", 32'(gpio_o), 32'hA5);
    rd(5'h04, v); chk("data_out_rb", v, 32'hA5);
    rd(5'h1C, v); chk("unmapped_rd", v, 32'h00);
    addr = 5'h04; wdata = 32'h3C; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("wr_rd_old", rdata, 32'hA5);
    chk("wr_rd_ack", 32'(ack), 32'd1);
    chk("wr_rd_gpio_o", 32'(gpio_o), 32'h3C);
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'd0);
    chk("rdata_hold", rdata, 32'hA5);
    wr(5'h00, 32'hFF);
    rd(5'h00, v); chk("data_in_ro", v, 32'h01);
    rd(5'h07, v); chk("low_addr_ignored", v, 32'h3C);
    lat1 = -1; lat32 = -1;
    s_re = 1'b1; p1 = 1'b1; p32 = 32'hFFFFFFFF;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (lat1 < 0 && rd1 === 32'h1) lat1 = n - 1;
      if (lat32 < 0 && rd32 === 32'hFFFFFFFF) lat32 = n - 1;
    end
    s_re = 1'b0;
    chk("lat_w1_d1", 32'(lat1), 32'd3);
    chk("lat_w32_d255", 32'(lat32), 32'd257);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 8: number of GPIO input and output bits; legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept an input change; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port GPIO_i, input, WIDTH: asynchronous external input pins.
REQ-006 Port GPIO_o, output, WIDTH: registered output pins (DATA_OUT register).
REQ-007 Port addr, input, 5: byte address; bits [4:2] select the register, bits [1:0] ignored.
REQ-008 Port we / re, input, 1 each: write strobe and read strobe, one cycle each.
REQ-009 Port wdata, input, 32: write data.
REQ-010 Port rdata, output, 32: registered read data.
REQ-011 Port ack, output, 1: pulses for one cycle, the cycle after any we or re.
REQ-012 Port irq, output, 1: level interrupt request to the core.

Function
REQ-013 Register map (word index = addr[4:2]):
- 0 DATA_IN: RO, debounced input.
- 1 DATA_OUT: RW.
- 2 IRQ_EN: RW.
- 3 EDGE_SEL: RW; 1 = rising edge, 0 = falling edge.
- 4 IRQ_STATUS: RW1C.
- 5..7: unmapped.
REQ-014 Each GPIO_i bit passes through a 2-flop synchronizer before any other use.
REQ-015 Debounce, per bit:
- Counter clears whenever the synchronized value equals the stable value.
- Otherwise the counter increments.
- When the counter reaches DEB_CYCLES-1 while the value still differs, the stable value takes the synchronized value on that edge and the counter clears.
REQ-016 Total latency: a clean pin change held indefinitely appears in DATA_IN exactly 2+DEB_CYCLES cycles after the first sampling edge.
REQ-017 A pin glitch shorter than DEB_CYCLES synchronized cycles never changes DATA_IN.
REQ-018 Edge event: on the cycle the stable bit changes in the direction selected by EDGE_SEL, the matching IRQ_STATUS bit is set on the next edge.
REQ-019 irq = OR of (IRQ_STATUS & IRQ_EN), decoded combinationally from registers only.
REQ-020 Write to IRQ_STATUS clears each bit where wdata is 1; if a clear and a new event hit the same bit in the same cycle, set wins.
REQ-021 Reads:
- rdata is valid with ack, one cycle after re.
- Unused upper bits and unmapped addresses read 0.
- rdata holds its value between reads.
REQ-022 Writes:
- Take effect on the edge where we is sampled.
- Only bits [WIDTH-1:0] are stored.
- Writes to DATA_IN and to unmapped addresses are ignored but still acked.
REQ-023 Simultaneous we and re: the write is performed and rdata returns the pre-write value; a single ack is issued.
REQ-024 Changing EDGE_SEL affects only events occurring after the write edge; already-set status bits are not altered.

Reset
REQ-025 On rst high at a clock edge, the following all become 0: synchronizers, stable values, debounce counters, DATA_OUT, IRQ_EN, EDGE_SEL, IRQ_STATUS, rdata, ack, GPIO_o and irq.
REQ-026 Reset asserted mid-debounce discards the pending change; after reset release, a pin held at 1 produces a rising event 2+DEB_CYCLES cycles later.
REQ-027 Bus strobes asserted during reset are ignored and not acked.

Structure
REQ-028 Package gpio_pkg holds the register index constants and a counter-width function ($clog2 based) for DEB_CYCLES.
REQ-029 One sub-module, gpio_debounce: single bit containing synchronizer, counter and stable flop, with outputs stable and rise/fall pulses; instantiated WIDTH times via generate.

Verification
REQ-030 Reset: WIDTH=8, DEB_CYCLES=4, GPIO_i=0x0F during rst, release -> DATA_IN reads 0x00 until 6 cycles after release, then 0x0F.
REQ-031 Glitch: GPIO_i bit0 pulses high for 3 cycles -> DATA_IN stays 0x00, IRQ_STATUS stays 0x00.
REQ-032 Rising interrupt: IRQ_EN=0x01, EDGE_SEL=0x01, GPIO_i 0x00->0x01 held -> IRQ_STATUS=0x01 and irq=1 seven cycles after the change; write 0x01 to IRQ_STATUS -> irq=0 next cycle.
REQ-033 Set-wins: a W1C write to bit2 in the same cycle as a bit2 falling event with EDGE_SEL bit2=0 -> IRQ_STATUS bit2 remains 1.
REQ-034 Bus: write 0xFFFFFFA5 to DATA_OUT -> GPIO_o=0xA5 and readback 0x000000A5; read of addr 0x1C returns 0 with ack; simultaneous we/re on DATA_OUT returns the old value.
REQ-035 Parameter sweep: WIDTH=1/DEB_CYCLES=1 and WIDTH=32/DEB_CYCLES=255 -> latencies of 3 and 257 cycles respectively.
